lfsr_burst_gen: RTL and testbench

Parametrised Fibonacci LFSR pattern generator: the successor to the fixed 5-bit shift-register generator, with configurable width, tap mask and seed. It adds run-time seed load, all-zero lock-up protection, period-wrap detection and a counted burst mode with a start/busy/done handshake. It sits beside the lab's sequential test blocks as a pseudo-random stimulus and serial-bit source.

---
 rtl/lfsr_burst_gen.sv | 101 ++++++++++
 tb/tb_lfsr_burst_gen.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/lfsr_burst_gen.sv
// Fibonacci LFSR pattern generator with seed load, lock-up guard, wrap detect
// and a counted burst mode driven by a start/busy/done handshake.
//
// state | meaning
// IDLE  | free-run stepping on en; waiting for start
// RUN   | burst in progress; one step per cycle until the count expires
module lfsr_burst_gen #(
  parameter int               WIDTH = 5,
  parameter logic [WIDTH-1:0] TAPS  = 5'b10100,
  parameter logic [WIDTH-1:0] SEED  = 5'b10111,
  parameter int               LEN_W = 8
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  output logic [WIDTH-1:0] q,
  output logic             dout,
  output logic             busy,
  output logic             done,
  output logic             lockup,
  output logic             wrap
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state;
  logic [LEN_W-1:0] cnt;
  logic             fb;
  logic [WIDTH-1:0] q_step;

  always_comb begin
    fb     = ^(q & TAPS);
    q_step = {q[WIDTH-2:0], fb};
  end

  assign dout = q[WIDTH-1];

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state  <= IDLE;
      q      <= SEED;
      cnt    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      lockup <= 1'b0;
      wrap   <= 1'b0;
    end else begin
      done   <= 1'b0;
      lockup <= 1'b0;
      wrap   <= 1'b0;
      if (load) begin
        // a load always wins and silently aborts any burst
        state <= IDLE;
        busy  <= 1'b0;
        cnt   <= '0;
        if (load_val == '0) begin
          q      <= SEED;
          lockup <= 1'b1;
        end else begin
          q <= load_val;
        end
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              if (len != '0) begin
                cnt   <= len;
                state <= RUN;
                busy  <= 1'b1;
              end else begin
                done <= 1'b1;
              end
            end else if (en) begin
              q    <= q_step;
              wrap <= (q_step == SEED);
            end
          end
          RUN: begin
            q    <= q_step;
            wrap <= (q_step == SEED);
            cnt  <= cnt - LEN_W'(1);
            if (cnt == LEN_W'(1)) begin
              state <= IDLE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_lfsr_burst_gen.sv
// Self-checking bench for lfsr_burst_gen: directed vector table, hand-written
// burst corner cases and randomized traffic against a behavioural model.
module tb_lfsr_burst_gen;

  localparam int         W    = 5;
  localparam logic [4:0] SEED = 5'b10111;
  localparam logic [4:0] TAPS = 5'b10100;

  logic       clk = 1'b0;
  logic       resetn, en, load, start;
  logic [4:0] load_val;
  logic [7:0] len;
  logic [4:0] q;
  logic       dout, busy, done, lockup, wrap;

  int n_total = 0;
  int n_pass  = 0;

  // behavioural model state
  logic [4:0] mq;
  bit         mbusy, mdone, mlock, mwrap;
  int         mrem;

  lfsr_burst_gen dut (
    .clk(clk), .resetn(resetn), .en(en), .load(load), .load_val(load_val),
    .start(start), .len(len), .q(q), .dout(dout), .busy(busy),
    .done(done), .lockup(lockup), .wrap(wrap)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rn, en, ld;
    logic [4:0] lv;
    logic       st;
    logic [7:0] ln;
    logic [4:0] q;
    logic       bsy, dn, lk, wr;
  } vec_t;

  vec_t vq[$];

  function automatic void add(logic rn, logic e, logic ld, logic [4:0] lv,
                              logic st, logic [7:0] ln, logic [4:0] eq,
                              logic bsy, logic dn, logic lk, logic wr);
    vec_t v;
    v.rn = rn; v.en = e; v.ld = ld; v.lv = lv; v.st = st; v.ln = ln;
    v.q = eq; v.bsy = bsy; v.dn = dn; v.lk = lk; v.wr = wr;
    vq.push_back(v);
  endfunction

  // next state computed from the tap rule: parity of the tapped bits
  function automatic logic [4:0] nxt(input logic [4:0] s);
    int ones;
    ones = 0;
    for (int i = 0; i < W; i++)
      if (s[i] && TAPS[i]) ones++;
    return {s[3:0], ((ones % 2) == 1)};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp)
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    else
      n_pass++;
  endtask

  task automatic model_edge();
    mdone = 0; mlock = 0; mwrap = 0;
    if (!resetn) begin
      mq = SEED; mbusy = 0; mrem = 0;
    end else if (load) begin
      mbusy = 0; mrem = 0;
      if (load_val == 5'd0) begin mq = SEED; mlock = 1; end
      else mq = load_val;
    end else if (!mbusy && start) begin
      if (len == 8'd0) mdone = 1;
      else begin mbusy = 1; mrem = int'(len); end
    end else if (mbusy) begin
      mq = nxt(mq); mwrap = (mq == SEED); mrem--;
      if (mrem == 0) begin mbusy = 0; mdone = 1; end
    end else if (en) begin
      mq = nxt(mq); mwrap = (mq == SEED);
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".q"},      32'(q),      32'(mq));
    chk({tag, ".dout"},   32'(dout),   32'(mq[4]));
    chk({tag, ".busy"},   32'(busy),   32'(mbusy));
    chk({tag, ".done"},   32'(done),   32'(mdone));
    chk({tag, ".lockup"}, 32'(lockup), 32'(mlock));
    chk({tag, ".wrap"},   32'(wrap),   32'(mwrap));
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    resetn = 1; en = 0; load = 0; load_val = 0; start = 0; len = 0;
  endtask

  initial begin
    int wraps, distinct;
    bit seen[32];

    idle_inputs();
    resetn = 0;
    mq = 0; mbusy = 0; mrem = 0; mdone = 0; mlock = 0; mwrap = 0;
    #2;

    // rn en ld lv st ln | q busy done lockup wrap
    add(0, 0, 0, 5'b00000, 0, 8'd0, 5'b10111, 0, 0, 0, 0);
    add(1, 1, 0, 5'b00000, 0, 8'd0, 5'b01110, 0, 0, 0, 0);
    add(1, 1, 0, 5'b00000, 0, 8'd0, 5'b11101, 0, 0, 0, 0);
    add(1, 1, 0, 5'b00000, 0, 8'd0, 5'b11010, 0, 0, 0, 0);
    add(1, 0, 1, 5'b00000, 0, 8'd0, 5'b10111, 0, 0, 1, 0);
    add(1, 0, 1, 5'b01110, 0, 8'd0, 5'b01110, 0, 0, 0, 0);
    add(1, 0, 1, 5'b11101, 0, 8'd0, 5'b11101, 0, 0, 0, 0);
    add(1, 0, 0, 5'b00000, 1, 8'd4, 5'b11101, 1, 0, 0, 0);
    add(1, 0, 0, 5'b00000, 1, 8'd9, 5'b11010, 1, 0, 0, 0);
    add(1, 1, 0, 5'b00000, 0, 8'd0, 5'b10101, 1, 0, 0, 0);
    add(1, 0, 0, 5'b00000, 0, 8'd0, 5'b01010, 1, 0, 0, 0);
    add(1, 0, 0, 5'b00000, 0, 8'd0, 5'b10100, 0, 1, 0, 0);
    add(1, 1, 0, 5'b00000, 1, 8'd0, 5'b10100, 0, 1, 0, 0);
    add(1, 0, 0, 5'b00000, 0, 8'd0, 5'b10100, 0, 0, 0, 0);

    foreach (vq[k]) begin
      resetn = vq[k].rn; en = vq[k].en; load = vq[k].ld; load_val = vq[k].lv;
      start = vq[k].st; len = vq[k].ln;
      tick();
      chk($sformatf("vec%0d.q", k),      32'(q),      32'(vq[k].q));
      chk($sformatf("vec%0d.dout", k),   32'(dout),   32'(vq[k].q[4]));
      chk($sformatf("vec%0d.busy", k),   32'(busy),   32'(vq[k].bsy));
      chk($sformatf("vec%0d.done", k),   32'(done),   32'(vq[k].dn));
      chk($sformatf("vec%0d.lockup", k), 32'(lockup), 32'(vq[k].lk));
      chk($sformatf("vec%0d.wrap", k),   32'(wrap),   32'(vq[k].wr));
    end

    // full period free run from reset
    idle_inputs(); resetn = 0; tick();
    idle_inputs(); en = 1;
    wraps = 0; distinct = 0;
    for (int i = 0; i < 32; i++) seen[i] = 0;
    for (int s = 1; s <= 31; s++) begin
      tick();
      check_model("freerun");
      if (!seen[q]) distinct++;
      seen[q] = 1;
      if (wrap) wraps++;
    end
    chk("period.q_at_31", 32'(q), 32'(SEED));
    chk("period.distinct", 32'(distinct), 32'd31);
    chk("period.wrap_count", 32'(wraps), 32'd1);
    chk("period.zero_never", 32'(seen[0]), 32'd0);

    // reset in the middle of a burst
    idle_inputs(); start = 1; len = 8'd10; tick();
    idle_inputs();
    for (int s = 1; s <= 4; s++) begin tick(); check_model("rstburst"); end
    resetn = 0; tick();
    chk("rstburst.q", 32'(q), 32'(SEED));
    chk("rstburst.busy", 32'(busy), 32'd0);
    chk("rstburst.done", 32'(done), 32'd0);
    idle_inputs();
    for (int s = 0; s < 3; s++) begin tick(); check_model("rstburst.after"); end

    // load in the middle of a burst
    start = 1; len = 8'd10; tick();
    idle_inputs();
    for (int s = 1; s <= 2; s++) begin tick(); check_model("ldburst"); end
    load = 1; load_val = 5'b10011; tick();
    chk("ldburst.q", 32'(q), 32'h13);
    chk("ldburst.busy", 32'(busy), 32'd0);
    chk("ldburst.done", 32'(done), 32'd0);
    idle_inputs();
    for (int s = 0; s < 10; s++) begin tick(); check_model("ldburst.after"); end

    // back-to-back bursts: restart in the done cycle
    start = 1; len = 8'd2; tick();
    idle_inputs(); tick(); tick();
    chk("b2b.done", 32'(done), 32'd1);
    start = 1; len = 8'd1; tick();
    chk("b2b.busy_again", 32'(busy), 32'd1);
    idle_inputs(); tick(); check_model("b2b.end");

    // randomized traffic against the model
    for (int c = 0; c < 600; c++) begin
      resetn   = ($urandom_range(0, 99) >= 2);
      load     = ($urandom_range(0, 99) < 5);
      load_val = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      start    = ($urandom_range(0, 99) < 12);
      len      = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(0, 60))
                                             : 8'($urandom_range(0, 6));
      en       = $urandom_range(0, 1) == 1;
      tick();
      check_model("rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
